// File: rtl/jt49_env_timer.sv
`default_nettype none
// ============================================================================
// Module   : jt49_env_timer
// Brief    : JT49 envelope register decode (R11/R12/R13), cen prescaler and
//            envelope period timer producing step, null_period, restart, ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module jt49_env_timer #(
  parameter int PRESCALE = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                wr,
  input  logic [3:0]          addr,
  input  logic [7:0]          din,
  output logic                step,
  output logic                null_period,
  output logic                restart,
  output logic [3:0]          ctrl,
  output logic [PERIOD_W-1:0] period
);

  localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              EXT_W     = (PERIOD_W > 16) ? PERIOD_W : 16;
  localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [3:0]      c_ADDR_LO = 4'd11;
  localparam logic [3:0]      c_ADDR_HI = 4'd12;
  localparam logic [3:0]      c_ADDR_SH = 4'd13;

  logic [PS_W-1:0]     r_pre;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_step;
  logic                r_null;
  logic                r_restart;
  logic [3:0]          r_ctrl;

  logic                w_wr_lo;
  logic                w_wr_hi;
  logic                w_wr_shape;
  logic                w_tick;
  logic                w_wrap;
  logic [EXT_W-1:0]    w_period_ext;
  logic [PERIOD_W-1:0] w_period_nxt;
  logic [PERIOD_W-1:0] w_last;

  assign w_wr_lo    = wr && (addr == c_ADDR_LO);
  assign w_wr_hi    = wr && (addr == c_ADDR_HI);
  assign w_wr_shape = wr && (addr == c_ADDR_SH);

  // Byte lanes are merged at 16 bits wide, then trimmed to the period width
  always_comb begin
    w_period_ext = EXT_W'(r_period);
    if (w_wr_lo) w_period_ext[7:0]  = din;
    if (w_wr_hi) w_period_ext[15:8] = din;
  end

  assign w_period_nxt = w_period_ext[PERIOD_W-1:0];

  assign w_tick = cen && (r_pre == c_PS_LAST);

  // period 0 counts like period 1; >= lets a lowered period wrap at once
  assign w_last = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);
  assign w_wrap = (r_cnt >= w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_ctrl    <= '0;
      r_null    <= 1'b1;
      r_restart <= 1'b0;
    end else begin
      r_period  <= w_period_nxt;
      r_null    <= (w_period_nxt == '0);
      r_restart <= w_wr_shape;
      if (w_wr_shape) r_ctrl <= din[3:0];
    end
  end

  // A shape write overrides any tick in the same clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (w_wr_shape) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      if (cen) r_pre <= w_tick ? '0 : r_pre + PS_W'(1);
      if (w_tick) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_step <= ~r_step;
        end else begin
          r_cnt  <= r_cnt + PERIOD_W'(1);
        end
      end
    end
  end

  assign step        = r_step;
  assign null_period = r_null;
  assign restart     = r_restart;
  assign ctrl        = r_ctrl;
  assign period      = r_period;

endmodule
`default_nettype wire

// File: tb/tb_jt49_env_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt49_env_timer
// Brief    : Scoreboard bench for jt49_env_timer (PRESCALE=4), directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt49_env_timer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen   = 1'b0;
  logic        wr    = 1'b0;
  logic [3:0]  addr  = 4'd0;
  logic [7:0]  din   = 8'd0;
  logic        step;
  logic        null_period;
  logic        restart;
  logic [3:0]  ctrl;
  logic [15:0] period;

  jt49_env_timer #(.PRESCALE(4), .PERIOD_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .wr         (wr),
    .addr       (addr),
    .din        (din),
    .step       (step),
    .null_period(null_period),
    .restart    (restart),
    .ctrl       (ctrl),
    .period     (period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {step, null_period, restart, ctrl, period}
  typedef struct {
    int          cyc;
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  wire [22:0] dut_v = {step, null_period, restart, ctrl, period};

  task automatic compare(input string name, input logic [22:0] act, input logic [22:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got step=%0b null=%0b restart=%0b ctrl=%h period=%h, want step=%0b null=%0b restart=%0b ctrl=%h period=%h",
               name, act[22], act[21], act[20], act[19:16], act[15:0],
               want[22], want[21], want[20], want[19:16], want[15:0]);
    end
  endtask

  // Monitor: pops every expectation due at this sample point
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: sample for cycle %0d missed at cycle %0d, want on time", e.name, e.cyc, cyc);
      end else begin
        compare(e.name, dut_v, e.v);
      end
    end
  end

  task automatic drive(input bit w, input logic [3:0] a, input logic [7:0] d, input bit c);
    @(negedge clk);
    wr   = w;
    addr = a;
    din  = d;
    cen  = c;
  endtask

  // Expected outputs after the next active edge
  task automatic expect1(input string name, input logic s, input logic n, input logic r,
                         input logic [3:0] ct, input logic [15:0] p);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.v    = {s, n, r, ct, p};
    q.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      drive(0, 4'd0, 8'h00, 0); expect1("reset_hold", 0, 1, 0, 4'h0, 16'h0000);
    end
    drive(0, 4'd0, 8'h00, 0); rst_n = 1'b1;
    expect1("reset_release", 0, 1, 0, 4'h0, 16'h0000);

    // Period 2 at PRESCALE 4: step toggles every 8 cen
    drive(1, 4'd11, 8'h02, 0); expect1("wr_r11", 0, 0, 0, 4'h0, 16'h0002);
    drive(1, 4'd12, 8'h00, 0); expect1("wr_r12", 0, 0, 0, 4'h0, 16'h0002);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 4'd0, 8'h00, 1);
      expect1("step_8cen", (i >= 8 && i < 16), 0, 0, 4'h0, 16'h0002);
    end

    // Shape write mid-period with step high
    for (int i = 1; i <= 10; i++) begin
      drive(0, 4'd0, 8'h00, 1);
      expect1("pre_r13", (i >= 8), 0, 0, 4'h0, 16'h0002);
    end
    drive(1, 4'd13, 8'h0E, 1); expect1("r13_restart", 0, 0, 1, 4'hE, 16'h0002);
    for (int j = 1; j <= 8; j++) begin
      drive(0, 4'd0, 8'h00, 1);
      expect1("r13_retime", (j == 8), 0, 0, 4'hE, 16'h0002);
    end

    // Period 0x100, count to 200, then lower period to 0x10
    drive(1, 4'd12, 8'h01, 0); expect1("wr_r12_hi", 1, 0, 0, 4'hE, 16'h0102);
    drive(1, 4'd11, 8'h00, 0); expect1("wr_r11_lo", 1, 0, 0, 4'hE, 16'h0100);
    drive(1, 4'd13, 8'h0A, 0); expect1("r13_clear", 0, 0, 1, 4'hA, 16'h0100);
    for (int i = 1; i <= 800; i++) begin
      drive(0, 4'd0, 8'h00, 1);
      if (i == 800) expect1("cnt200", 0, 0, 0, 4'hA, 16'h0100);
    end
    drive(1, 4'd12, 8'h00, 0); expect1("wr_r12_zero", 0, 1, 0, 4'hA, 16'h0000);
    drive(1, 4'd11, 8'h10, 0); expect1("wr_r11_0x10", 0, 0, 0, 4'hA, 16'h0010);
    for (int i = 1; i <= 68; i++) begin
      drive(0, 4'd0, 8'h00, 1);
      if (i == 3 || i == 4 || i == 67 || i == 68)
        expect1("lowered_wrap", (i == 4 || i == 67), 0, 0, 4'hA, 16'h0010);
    end

    // Shape write coinciding with a tick that would toggle step
    drive(1, 4'd11, 8'h01, 0); expect1("wr_period1", 0, 0, 0, 4'hA, 16'h0001);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 4'd0, 8'h00, 1); expect1("pre_count", 0, 0, 0, 4'hA, 16'h0001);
    end
    drive(1, 4'd13, 8'h05, 1); expect1("r13_vs_tick", 0, 0, 1, 4'h5, 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 4'd0, 8'h00, 1);
      expect1("after_r13_tick", (i == 4), 0, 0, 4'h5, 16'h0001);
    end
    drive(1, 4'd14, 8'hFF, 0); expect1("addr14_ignored", 1, 0, 0, 4'h5, 16'h0001);

    // Async reset mid-count
    drive(1, 4'd11, 8'h03, 0); expect1("wr_p3", 1, 0, 0, 4'h5, 16'h0003);
    drive(1, 4'd12, 8'h01, 0); expect1("wr_p103", 1, 0, 0, 4'h5, 16'h0103);
    for (int i = 1; i <= 6; i++) begin
      drive(0, 4'd0, 8'h00, 1); expect1("midcount", 1, 0, 0, 4'h5, 16'h0103);
    end
    @(negedge clk);
    cen = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare("async_reset", dut_v, {1'b0, 1'b1, 1'b0, 4'h0, 16'h0000});
    drive(0, 4'd0, 8'h00, 1); expect1("reset_held", 0, 1, 0, 4'h0, 16'h0000);
    drive(0, 4'd0, 8'h00, 0); rst_n = 1'b1;
    expect1("reset_released", 0, 1, 0, 4'h0, 16'h0000);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
